// File: rtl/imm_extend_stage.sv
// LEGv8 immediate-extension pipeline stage.
// Each accepted instruction word is decoded into an extension kind and a
// 64-bit immediate. The result is held in a two-entry register buffer
// (main + skid). The consumer always sees the main entry. in_ready depends
// only on the skid valid bit, so there is no combinational path from
// out_ready to in_ready and none from instr to the outputs.

module imm_extend_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] imm,
  output logic [2:0]  imm_kind
);

  // Extension kinds presented on imm_kind. Values 5-7 are never produced.
  localparam logic [2:0] KIND_NONE = 3'd0;
  localparam logic [2:0] KIND_ZE12 = 3'd1;
  localparam logic [2:0] KIND_SE9  = 3'd2;
  localparam logic [2:0] KIND_SE19 = 3'd3;
  localparam logic [2:0] KIND_SE26 = 3'd4;

  // Opcode classification. Earlier tests take priority over later ones:
  // B, then CBZ, then ADDI/SUBI, then LDUR/STUR.
  function automatic logic [2:0] decode_kind(input logic [31:0] w);
    logic [2:0] k;
    if (w[31:26] == 6'b000101) begin
      k = KIND_SE26;
    end else if (w[31:24] == 8'b1011_0100) begin
      k = KIND_SE19;
    end else if ((w[31:22] == 10'b10_0100_0100) ||
                 (w[31:22] == 10'b11_0100_0100)) begin
      k = KIND_ZE12;
    end else if ((w[31:21] == 11'b111_1100_0010) ||
                 (w[31:21] == 11'b111_1100_0000)) begin
      k = KIND_SE9;
    end else begin
      k = KIND_NONE;
    end
    return k;
  endfunction

  // Immediate formation for a given kind. Branch offsets are word
  // offsets, so they are scaled by 4 before sign extension.
  function automatic logic [63:0] form_imm(input logic [2:0]  kind,
                                           input logic [31:0] w);
    logic [63:0] v;
    case (kind)
      KIND_ZE12: v = {52'd0, w[21:10]};
      KIND_SE9:  v = {{55{w[20]}}, w[20:12]};
      KIND_SE19: v = {{43{w[23]}}, w[23:5], 2'b00};
      KIND_SE26: v = {{36{w[25]}}, w[25:0], 2'b00};
      default:   v = 64'd0;
    endcase
    return v;
  endfunction

  // Buffer state. Only the valid bits are reset. The data registers of an
  // empty entry hold stale values that are never observed.
  logic        main_valid_q, main_valid_d;
  logic [63:0] main_imm_q,   main_imm_d;
  logic [2:0]  main_kind_q,  main_kind_d;
  logic        skid_valid_q, skid_valid_d;
  logic [63:0] skid_imm_q,   skid_imm_d;
  logic [2:0]  skid_kind_q,  skid_kind_d;

  logic [2:0]  dec_kind;
  logic [63:0] dec_imm;
  logic        accept;
  logic        xfer;

  // Decode the incoming word and qualify the two handshakes.
  always_comb begin
    dec_kind = decode_kind(instr);
    dec_imm  = form_imm(dec_kind, instr);
    accept   = in_valid & ~skid_valid_q & ~flush;
    xfer     = main_valid_q & out_ready;
  end

  // Next-state selection for the main and skid entries.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_kind_d  = main_kind_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_kind_d  = skid_kind_q;

    if (flush) begin
      // Flush wins over any transfer or acceptance in the same cycle.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Both entries full: in_ready is low, so nothing is accepted.
      if (xfer) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_kind_d  = skid_kind_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
    end else if (!main_valid_q || xfer) begin
      // Main is free (or freeing this cycle): a new word goes straight in.
      main_valid_d = accept;
      if (accept) begin
        main_imm_d  = dec_imm;
        main_kind_d = dec_kind;
      end else begin
        main_imm_d  = main_imm_q;
      end
    end else begin
      // Main is stalled: park a new word in the skid entry.
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_kind_d  = dec_kind;
      end else begin
        skid_valid_d = 1'b0;
      end
    end
  end

  // Valid bits: asynchronous clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers: no reset, they only matter while their entry is valid.
  always_ff @(posedge clk) begin
    main_imm_q  <= main_imm_d;
    main_kind_q <= main_kind_d;
    skid_imm_q  <= skid_imm_d;
    skid_kind_q <= skid_kind_d;
  end

  // Outputs come only from registers. The payload is masked by the main
  // valid bit, so imm and imm_kind read zero during and right after reset.
  always_comb begin
    out_valid = main_valid_q;
    in_ready  = ~skid_valid_q;
    if (main_valid_q) begin
      imm      = main_imm_q;
      imm_kind = main_kind_q;
    end else begin
      imm      = 64'd0;
      imm_kind = KIND_NONE;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed testbench for imm_extend_stage.
// The reference model is a FIFO queue with capacity two. It holds the
// {kind, imm} pairs that the stage has accepted. A compare process checks
// the DUT against this queue on every falling edge. Literal checks fix the
// expected values for the listed instruction encodings.

module tb_imm_extend_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] imm;
  logic [2:0]  imm_kind;

  int checks = 0;
  int errors = 0;

  logic [66:0] q[$];

  imm_extend_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .imm_kind  (imm_kind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode. It uses signed arithmetic and first-match priority.
  function automatic logic [66:0] model_entry(input logic [31:0] w);
    logic signed [8:0]  s9;
    logic signed [18:0] s19;
    logic signed [25:0] s26;
    longint             v;
    logic [2:0]         k;
    logic [63:0]        u;
    s9  = w[20:12];
    s19 = w[23:5];
    s26 = w[25:0];
    casez (w[31:21])
      11'b000101?????: begin k = 3'd4; v = longint'(s26) * 4; end
      11'b10110100???: begin k = 3'd3; v = longint'(s19) * 4; end
      11'b1001000100?,
      11'b1101000100?: begin k = 3'd1; v = longint'(w[21:10]); end
      11'b11111000010,
      11'b11111000000: begin k = 3'd2; v = longint'(s9); end
      default:         begin k = 3'd0; v = 0; end
    endcase
    u = v;
    return {k, u};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a capacity-2 FIFO. Flush and reset empty it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      if (in_valid && (q.size() < 2)) begin
        if (out_ready && (q.size() > 0)) void'(q.pop_front());
        q.push_back(model_entry(instr));
      end else if (out_ready && (q.size() > 0)) begin
        void'(q.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    check("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
    if (q.size() > 0) begin
      check("imm",      imm,              q[0][63:0]);
      check("imm_kind", {61'd0, imm_kind}, {61'd0, q[0][66:64]});
    end else if (reset) begin
      check("imm_rst",  imm,              64'd0);
      check("kind_rst", {61'd0, imm_kind}, 64'd0);
    end
  end

  // Pin the model, then send one word with out_ready=1 and check the
  // DUT output one cycle later. The caller must be at a falling edge.
  task automatic lit(input string name, input logic [31:0] w,
                     input logic [63:0] eimm, input logic [2:0] ekind);
    logic [66:0] m;
    m = model_entry(w);
    check({name, "_model_imm"},  m[63:0],               eimm);
    check({name, "_model_kind"}, {61'd0, m[66:64]},     {61'd0, ekind});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = w;
    @(negedge clk);
    in_valid  = 1'b0;
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_imm"},   imm,                eimm);
    check({name, "_kind"},  {61'd0, imm_kind},  {61'd0, ekind});
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [31:0] w_addi, w_ldur, w_cbz, w_b, w_add, w_subi, w_stur, w_cbzn, w_bp;
  logic [31:0] tbl [8];
  logic [47:0] iv_pat, or_pat;

  initial begin
    w_addi = {10'b1001000100, 12'hFFF, 5'd1, 5'd2};
    w_ldur = {11'b11111000010, 9'h1F0, 2'b00, 5'd3, 5'd4};
    w_cbz  = {8'b10110100, 19'h00001, 5'd5};
    w_b    = {6'b000101, 26'h3FFFFFF};
    w_add  = 32'h8B020020;
    w_subi = {10'b1101000100, 12'h800, 10'd0};
    w_stur = {11'b11111000000, 9'h0FF, 12'd0};
    w_cbzn = {8'b10110100, 19'h40000, 5'd0};
    w_bp   = {6'b000101, 26'h0000010};
    tbl[0] = w_addi; tbl[1] = w_ldur; tbl[2] = w_cbz;  tbl[3] = w_b;
    tbl[4] = w_add;  tbl[5] = w_subi; tbl[6] = w_stur; tbl[7] = w_cbzn;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic decode cases. The first one is accepted on the first edge
    // after reset is released.
    lit("addi",  w_addi, 64'h0000_0000_0000_0FFF, 3'd1);
    lit("ldur",  w_ldur, 64'hFFFF_FFFF_FFFF_FFF0, 3'd2);
    lit("cbz",   w_cbz,  64'h0000_0000_0000_0004, 3'd3);
    lit("b",     w_b,    64'hFFFF_FFFF_FFFF_FFFC, 3'd4);
    lit("add",   w_add,  64'h0000_0000_0000_0000, 3'd0);
    lit("subi",  w_subi, 64'h0000_0000_0000_0800, 3'd1);
    lit("stur",  w_stur, 64'h0000_0000_0000_00FF, 3'd2);
    lit("cbzn",  w_cbzn, 64'hFFFF_FFFF_FFF0_0000, 3'd3);
    lit("bpos",  w_bp,   64'h0000_0000_0000_0040, 3'd4);

    // Backpressure: two words back to back fill both entries.
    out_ready = 1'b0;
    push(w_addi);
    push(w_b);
    check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
    check("bp_first_held",    imm, 64'h0000_0000_0000_0FFF);
    @(negedge clk);
    check("bp_stable",        imm, 64'h0000_0000_0000_0FFF);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second",        imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    check("bp_drained",       {63'd0, out_valid}, 64'd0);

    // Flush with both entries full and a word offered in the same cycle.
    out_ready = 1'b0;
    push(w_cbz);
    push(w_ldur);
    flush = 1'b1; in_valid = 1'b1; instr = w_subi;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_in_ready",  {63'd0, in_ready},  64'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Mixed stream with irregular valid/ready patterns and one flush.
    iv_pat = 48'hF3B5_9E6D_C7A1;
    or_pat = 48'h9D6E_35F1_AB2C;
    for (int i = 0; i < 48; i++) begin
      in_valid  = iv_pat[i];
      out_ready = or_pat[i];
      instr     = tbl[i % 8];
      flush     = (i == 30);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset in mid-cycle while out_valid is high.
    out_ready = 1'b0;
    push(w_b);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_imm",       imm,                64'd0);
    check("rst_kind",      {61'd0, imm_kind},  64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    reset = 1'b0;
    lit("post_rst_cbz",  w_cbz,  64'h0000_0000_0000_0004, 3'd3);
    lit("post_rst_ldur", w_ldur, 64'hFFFF_FFFF_FFFF_FFF0, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
